// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block: FSM encoding,
// default mul/div latency and a saturating down-count helper.
package pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } pipe_state_e;

    localparam int MD_LATENCY_DEF = 32;

    // Decrement an 8-bit count, holding at zero instead of wrapping.
    function automatic logic [7:0] sat_dec(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'd0) begin
            result = 8'd0;
        end else begin
            result = value - 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear and increment enable.
// Wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count qualifying events; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. Decodes memory waits, multi-cycle
// mul/div occupancy, load-use hazards and taken jumps into per-stage
// register enables and bubble inserts, and counts stall/flush cycles.
// The enables/flushes are decoded from the current-cycle requests so the
// stage registers react in the same cycle the condition is seen.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             ID_jumpTaken,
    input  logic             EX_mdStart,
    input  logic             MEM_memReq,
    input  logic             mem_ready,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             MEMWB_flush,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    pipe_state_e state_r;
    logic [7:0]  md_cnt_r;
    logic        memwait_s;
    logic        md_start_s;
    logic        md_done_s;

    assign memwait_s  = MEM_memReq & ~mem_ready;
    assign md_start_s = (state_r == RUN) & EX_mdStart & ~memwait_s;
    assign md_done_s  = (state_r == MD_BUSY) & (md_cnt_r == 8'd0) & ~memwait_s;

    // FSM: track mul/div occupancy and its remaining busy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            md_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (md_start_s) begin
                        state_r  <= MD_BUSY;
                        md_cnt_r <= MD_LOAD;
                    end else begin
                        state_r  <= RUN;
                        md_cnt_r <= md_cnt_r;
                    end
                end
                MD_BUSY: begin
                    md_cnt_r <= sat_dec(md_cnt_r);
                    if (md_done_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= MD_BUSY;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    md_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Output decode: reset, then memory wait, then mul/div freeze, then
    // normal flow with hazard stall taking precedence over a taken jump.
    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IDEX_en     = 1'b1;
        EXMEM_en    = 1'b1;
        MEMWB_en    = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        MEMWB_flush = 1'b0;
        md_done     = 1'b0;
        if (rst) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWB_en    = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            MEMWB_flush = 1'b1;
        end else if (memwait_s) begin
            // Whole pipe holds; the access in MEM is not retired yet.
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWB_en    = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (md_start_s || ((state_r == MD_BUSY) && !md_done_s)) begin
            // Front end holds behind the mul/div; older work drains.
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            EXMEM_flush = 1'b1;
        end else begin
            md_done = md_done_s;
            if (hazard_stall) begin
                PC_en      = 1'b0;
                IFID_en    = 1'b0;
                IDEX_en    = 1'b0;
                IDEX_flush = 1'b1;
            end else if (ID_jumpTaken) begin
                IFID_en    = 1'b0;
                IFID_flush = 1'b1;
            end else begin
                PC_en = 1'b1;
            end
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (~PC_en),
        .cnt (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (IFID_flush | IDEX_flush),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MD_LATENCY=4, CNT_W=4).
module tb_pipeline_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hazard_stall = 1'b0;
    logic          ID_jumpTaken = 1'b0;
    logic          EX_mdStart = 1'b0;
    logic          MEM_memReq = 1'b0;
    logic          mem_ready = 1'b0;
    logic          PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic          IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush;
    logic          md_done;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [4:0]    en;
        logic [3:0]    fl;
        logic          done;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic          m_busy = 1'b0;
    int            m_left = 0;
    logic [CW-1:0] m_scnt = '0;
    logic [CW-1:0] m_fcnt = '0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .ID_jumpTaken (ID_jumpTaken),
        .EX_mdStart   (EX_mdStart),
        .MEM_memReq   (MEM_memReq),
        .mem_ready    (mem_ready),
        .PC_en        (PC_en),
        .IFID_en      (IFID_en),
        .IDEX_en      (IDEX_en),
        .EXMEM_en     (EXMEM_en),
        .MEMWB_en     (MEMWB_en),
        .IFID_flush   (IFID_flush),
        .IDEX_flush   (IDEX_flush),
        .EXMEM_flush  (EXMEM_flush),
        .MEMWB_flush  (MEMWB_flush),
        .md_done      (md_done),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock: drive inputs, predict outputs, compare at the falling edge.
    task automatic step(input logic r, input logic hs, input logic jt,
                        input logic mds, input logic mreq, input logic mrdy);
        exp_t e;
        logic mw;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; hazard_stall = hs; ID_jumpTaken = jt;
        EX_mdStart = mds; MEM_memReq = mreq; mem_ready = mrdy;
        mw = mreq && !mrdy;
        e.done = 1'b0;
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        // en = {PC,IFID,IDEX,EXMEM,MEMWB}, fl = {IFID,IDEX,EXMEM,MEMWB}
        if (r) begin
            e.en = 5'b00000; e.fl = 4'b1111;
            m_busy = 1'b0; m_left = 0;
        end else if (mw) begin
            e.en = 5'b00000; e.fl = 4'b0001;
            if (m_busy && m_left > 0) m_left--;
        end else if ((m_busy && m_left > 0) || (!m_busy && mds)) begin
            e.en = 5'b00001; e.fl = 4'b0010;
            if (m_busy) m_left--;
            else begin m_busy = 1'b1; m_left = LAT - 1; end
        end else begin
            e.done = m_busy;
            m_busy = 1'b0;
            if (hs) begin
                e.en = 5'b00011; e.fl = 4'b0100;
            end else if (jt) begin
                e.en = 5'b10111; e.fl = 4'b1000;
            end else begin
                e.en = 5'b11111; e.fl = 4'b0000;
            end
        end
        if (r) begin
            m_scnt = '0; m_fcnt = '0;
        end else begin
            if (!e.en[4]) m_scnt = m_scnt + 4'd1;
            if (e.fl[3] || e.fl[2]) m_fcnt = m_fcnt + 4'd1;
        end
        exp_q.push_back(e);
        @(negedge clk);
        begin
            exp_t x;
            x = exp_q.pop_front();
            check_eq("en", {27'd0, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en}, {27'd0, x.en});
            check_eq("flush", {28'd0, IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush}, {28'd0, x.fl});
            check_eq("md_done", {31'd0, md_done}, {31'd0, x.done});
            check_eq("stall_cnt", {28'd0, stall_cnt}, {28'd0, x.scnt});
            check_eq("flush_cnt", {28'd0, flush_cnt}, {28'd0, x.fcnt});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset values
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        // first cycle after release: all enabled, counters zero
        idle(1);
        // hazard with concurrent jump: jump ignored
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // jump alone
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // mul/div with start held through the done cycle
        for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // memwait during MD_BUSY delays md_done
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // memwait exactly on the md_cnt==0 cycle, then hazard on done
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);
        // reset mid MD_BUSY with md_cnt==2
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        // memwait in RUN blocks a mul/div start
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        // counter wrap: clear, 15 stalls to reach 15, then two more
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
        end
        idle(LAT + 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32, meaning mul/div busy cycles, legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of performance counters.
REQ-003 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port hazard_stall input 1: load-use/branch-operand stall request from hazard detection.
REQ-006 SHALL have port ID_jumpTaken input 1: control transfer resolved taken in ID.
REQ-007 SHALL have port EX_mdStart input 1: multi-cycle mul/div instruction present in EX.
REQ-008 SHALL have ports MEM_memReq input 1 and mem_ready input 1: data-memory access in MEM; access completes in a cycle where both are high.
REQ-009 SHALL have outputs PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, each 1 bit: stage register load enables.
REQ-010 SHALL have outputs IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush, each 1 bit: load bubble into that register.
REQ-011 SHALL have outputs md_done 1 bit, stall_cnt CNT_W bits, flush_cnt CNT_W bits.

Function
REQ-012 SHALL implement FSM states RUN and MD_BUSY plus an 8-bit down-counter md_cnt.
REQ-013 SHALL define memwait = MEM_memReq && !mem_ready, evaluated combinationally every cycle, highest priority.
REQ-014 When memwait: PC_en, IFID_en, IDEX_en, EXMEM_en SHALL be 0, MEMWB_flush SHALL be 1, all other flushes 0, in either state.
REQ-015 In RUN with EX_mdStart, no memwait, and md_done not asserted this cycle: SHALL load md_cnt = MD_LATENCY-1 and go to MD_BUSY next cycle; outputs that cycle as REQ-016.
REQ-016 In MD_BUSY, or in the RUN start cycle: PC_en, IFID_en, IDEX_en SHALL be 0, EXMEM_flush SHALL be 1, MEMWB_en 1.
REQ-017 In MD_BUSY md_cnt SHALL decrement each cycle and saturate at 0, including during memwait.
REQ-018 In MD_BUSY with md_cnt==0 and no memwait: md_done SHALL be 1 for exactly that cycle, all enables 1 with all flushes 0 (subject to REQ-021 and REQ-022), next state RUN.
REQ-019 EX_mdStart SHALL be ignored in the md_done cycle.
REQ-020 In RUN, no memwait, no mul/div start: all enables SHALL default to 1 and all flushes to 0.
REQ-021 In that case, with hazard_stall: PC_en=0, IFID_en=0, IDEX_flush=1.
REQ-022 In that case, with ID_jumpTaken and no hazard_stall: IFID_flush=1; if hazard_stall is also asserted, the jump SHALL be ignored that cycle.
REQ-023 An enable and flush for the same register SHALL never be 1 simultaneously; flush implies enable=1 semantics at the register.
REQ-024 stall_cnt SHALL increment by 1 in every non-reset cycle with PC_en==0, wrapping modulo 2^CNT_W.
REQ-025 flush_cnt SHALL increment by 1 in every non-reset cycle with IFID_flush or IDEX_flush asserted, wrapping modulo 2^CNT_W.

Reset
REQ-026 While rst is high: state RUN, md_cnt 0, stall_cnt 0, flush_cnt 0, md_done 0, all *_en 0, all *_flush 1.
REQ-027 rst asserted mid MD_BUSY SHALL abort the operation; first post-reset cycle SHALL be RUN with no md_done.

Structure
REQ-028 State encoding (RUN=0, MD_BUSY=1) and MD_LATENCY default SHALL live in shared package pipe_pkg.
REQ-029 SHALL contain one sub-module perf_counter (CNT_W-bit, sync clear, increment enable), instantiated twice; FSM and output decode SHALL stay in pipeline_ctrl.

Verification (MD_LATENCY=4)
REQ-030 Release rst, no requests -> all enables 1, flushes 0, counters 0 on the first cycle.
REQ-031 hazard_stall=1 for 1 cycle, concurrent ID_jumpTaken=1 -> PC_en=0, IDEX_flush=1, IFID_flush=0; stall_cnt=1, flush_cnt=1.
REQ-032 EX_mdStart=1 held -> 4 frozen cycles (start + 3 MD_BUSY), md_done on 5th cycle only, then RUN; stall_cnt=4.
REQ-033 MEM_memReq=1, mem_ready=0 for 3 cycles during MD_BUSY -> full freeze, MEMWB_flush=1, md_done delayed until the first cycle without memwait.
REQ-034 rst pulsed 1 cycle during MD_BUSY with md_cnt=2 -> next cycle RUN, md_done never asserted, counters 0.
REQ-035 stall_cnt preset near 2^CNT_W-1 (CNT_W=4), 2 stall cycles -> wraps to 0 then 1.
